clk_div_n: RTL and testbench
============================

Name: clk_div_n

Overview:
Parametrised integer clock divider. It produces a divided clock-enable/clock output `q_o` with a runtime-programmable divisor N ≥ 2, plus a one-cycle `tick_o` pulse per output period. Divisor changes are glitch-free: they take effect only at a period boundary. It is the general-purpose successor to the fixed divide-by-3 block, for use wherever the design needs a slow clock or strobe derived from `clk_i`.

Parameters:
- CNT_W, 8, width of divisor and internal counter; legal N range is 2 .. 2**CNT_W-1.
- DIV_RST, 3, divisor loaded at reset; values below 2 are clamped to 2.

Ports:
- clk_i  input  1  single clock; all state updates on the rising edge unless stated otherwise.
- rst_i  input  1  synchronous, active-high reset.
- en_i  input  1  divider run enable.
- div_i  input  CNT_W  new divisor value.
- div_load_i  input  1  1-cycle strobe to capture `div_i`.
- q_o  output  1  divided output, period N clk_i cycles.
- tick_o  output  1  1-cycle pulse on the first cycle of each output period.
- div_o  output  CNT_W  divisor currently in effect.
- cfg_err_o  output  1  1-cycle pulse when a loaded `div_i` is below 2.

Behaviour:
- Internal state:
  - `cnt`, CNT_W bits, range 0..N-1.
  - `act_div`, the divisor in effect.
  - `pend_div` and `pend_vld`, the pending divisor.
  - `q_pos`, the rising-edge output register.
- Reset, while `rst_i` is high at a rising edge:
  - cnt=0, q_pos=0, q_o=0, tick_o=0, cfg_err_o=0, pend_vld=0.
  - act_div = max(DIV_RST, 2), so div_o = act_div.
- Idle (`en_i` low): cnt=0, q_pos=0, tick_o=0. A pending divisor is applied immediately.
- Run (`en_i` high), evaluated at each rising edge:
  - Wrap condition: en_i was low in the previous cycle, or cnt==act_div-1.
    - On wrap: cnt ← 0, tick_o ← 1, and act_div ← pend_div if pend_vld (pend_vld then clears).
    - Otherwise: cnt ← cnt+1, tick_o ← 0.
  - q_pos ← 1 when the new cnt < H, else 0. H = floor(N/2), where N is the act_div value in force for the new cnt.
  - First edge with en_i sampled high: q_o=1 and tick_o=1 are both registered at that edge, so latency is 1 edge.
- Duty cycle in base build: high for floor(N/2) cycles, low for ceil(N/2) cycles.
  - Even N: exactly 50%.
  - N=3: high 1 cycle, low 2 cycles.
- Divisor load:
  - When div_load_i=1, capture clamp(div_i) = max(div_i, 2) into pend_div and set pend_vld=1.
  - If div_i < 2, cfg_err_o=1 for one cycle (registered) and the value 2 is used.
  - Several loads before a wrap: the last one wins.
  - Load on the same edge as a wrap: div_i is applied directly to the period starting at that edge, bypassing pend.
- en_i deasserted mid-period: on the next edge q_o goes low and cnt=0. The truncated period does not produce tick_o. Re-enabling always starts a fresh full period.
- Reset mid-operation overrides everything, including a pending divisor, which is discarded.
- No combinational path from any input to q_o or tick_o.

Optional Feature:
- Macro: CLK_DIV_ODD_DUTY50_EN.
- Defined:
  - Add `q_neg`, a falling-edge register with q_neg ← q_pos. It clears on any falling edge while rst_i=1.
  - For odd N: q_o = q_pos | q_neg. The high time becomes N/2 cycles, i.e. exactly 50%. For N=3 that is 1.5 cycles high and 1.5 low.
  - For even N: q_o = q_pos, unchanged.
- Undefined: no falling-edge logic, q_o = q_pos. Duty cycle as stated in Behaviour.

Test Plan:
- Reset with DIV_RST=3, then en_i=1 → tick_o every 3 cycles, q_o pattern 1,0,0 repeating, div_o=3.
- Load div_i=8 mid-period with cnt=1 → current 3-cycle period completes. The next period is 8 cycles with 4 high and 4 low, and div_o changes to 8 at that boundary.
- Load div_i=0, then 1 → cfg_err_o pulses once per load, div_o=2 after the boundary, q_o toggles 1,0.
- en_i dropped at cnt=2 with N=5 → q_o=0 on the next edge. Re-enable gives tick_o on the first edge and a full 5-cycle period (2 high, 3 low).
- Assert rst_i for 2 cycles during a run with pend_vld=1 → all outputs 0, div_o=DIV_RST, and the pending divisor is discarded.
- With CLK_DIV_ODD_DUTY50_EN and N=5 → q_o high 2.5 cycles and low 2.5 cycles, measured rise-to-fall in simulation time. N=4 is identical to the base build.

Source files
------------

// File: rtl/clk_div_n.sv
// Integer clock divider with a runtime-programmable divisor applied only at period boundaries.
// Optional macro CLK_DIV_ODD_DUTY50_EN adds a falling-edge stage for 50% duty at odd divisors.
module clk_div_n #(
  parameter int CNT_W   = 8,
  parameter int DIV_RST = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             div_load_i,
  output logic             q_o,
  output logic             tick_o,
  output logic [CNT_W-1:0] div_o,
  output logic             cfg_err_o
);

  localparam int               DIV_RST_CL = (DIV_RST < 2) ? 2 : DIV_RST;
  localparam logic [CNT_W-1:0] DIV_INIT   = CNT_W'(DIV_RST_CL);
  localparam logic [CNT_W-1:0] DIV_MIN    = CNT_W'(2);

  logic [CNT_W-1:0] cnt, act_div, pend_div;
  logic             pend_vld, q_pos, tick, cfg_err, en_d;

  logic [CNT_W-1:0] nxt_cnt, nxt_act, nxt_pend, load_div;
  logic             nxt_pvld, nxt_tick, nxt_q, load_low, wrap;

  always_comb begin
    load_low = (div_i < DIV_MIN);
    load_div = load_low ? DIV_MIN : div_i;
    // A stopped divider always restarts with a fresh period.
    wrap     = !en_d || (cnt == act_div - 1'b1);

    nxt_cnt  = cnt;
    nxt_act  = act_div;
    nxt_pend = pend_div;
    nxt_pvld = pend_vld;
    nxt_tick = 1'b0;
    nxt_q    = 1'b0;

    if (!en_i || wrap) begin
      nxt_cnt  = '0;
      nxt_tick = en_i;
      // A load on a boundary edge goes straight to the new period.
      if (div_load_i) begin
        nxt_act  = load_div;
        nxt_pvld = 1'b0;
      end else if (pend_vld) begin
        nxt_act  = pend_div;
        nxt_pvld = 1'b0;
      end
    end else begin
      nxt_cnt = cnt + 1'b1;
      if (div_load_i) begin
        nxt_pend = load_div;
        nxt_pvld = 1'b1;
      end
    end

    if (en_i) begin
      nxt_q = (nxt_cnt < (nxt_act >> 1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt      <= '0;
      act_div  <= DIV_INIT;
      pend_div <= DIV_INIT;
      pend_vld <= 1'b0;
      q_pos    <= 1'b0;
      tick     <= 1'b0;
      cfg_err  <= 1'b0;
      en_d     <= 1'b0;
    end else begin
      cnt      <= nxt_cnt;
      act_div  <= nxt_act;
      pend_div <= nxt_pend;
      pend_vld <= nxt_pvld;
      q_pos    <= nxt_q;
      tick     <= nxt_tick;
      cfg_err  <= div_load_i && load_low;
      en_d     <= en_i;
    end
  end

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic q_neg;

  // Half-cycle delayed copy stretches the high phase by half a cycle for odd N.
  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      q_neg <= 1'b0;
    end else begin
      q_neg <= q_pos;
    end
  end

  assign q_o = act_div[0] ? (q_pos | q_neg) : q_pos;
`else
  assign q_o = q_pos;
`endif

  assign tick_o    = tick;
  assign div_o     = act_div;
  assign cfg_err_o = cfg_err;

endmodule

// File: tb/tb_clk_div_n.sv
// Directed table-driven bench for clk_div_n plus duty-cycle measurement in simulation time.
`timescale 1ns/1ps
module tb_clk_div_n;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             en_i = 1'b0;
  logic [CNT_W-1:0] div_i = '0;
  logic             div_load_i = 1'b0;
  logic             q_o, tick_o, cfg_err_o;
  logic [CNT_W-1:0] div_o;

  int errors = 0;
  int checks = 0;

  clk_div_n #(.CNT_W(CNT_W), .DIV_RST(3)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .div_i(div_i), .div_load_i(div_load_i),
    .q_o(q_o), .tick_o(tick_o), .div_o(div_o), .cfg_err_o(cfg_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             rst;
    logic             en;
    logic             load;
    logic [CNT_W-1:0] div;
    logic             q;
    logic             tick;
    logic [CNT_W-1:0] dv;
    logic             err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic en, input logic load, input int div,
                     input logic q, input logic tick, input int dv, input logic err);
    vec_t v;
    v.rst = rst; v.en = en; v.load = load; v.div = CNT_W'(div);
    v.q = q; v.tick = tick; v.dv = CNT_W'(dv); v.err = err;
    vecs.push_back(v);
  endtask

  task automatic check1(input string name, input int row, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  // Waits (bounded) for q_o to reach level lvl; returns the time it got there.
  task automatic wait_q(input logic lvl, output time t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 400; i++) begin
      if (q_o == lvl) begin
        ok = 1'b1;
        t  = $time;
        break;
      end
      #1;
    end
  endtask

  task automatic measure(input int n, input int exp_hi, input int exp_lo);
    time t0, t1, t2, tx;
    bit  ok0, ok1, ok2, okx;
    @(negedge clk);
    div_i = CNT_W'(n); div_load_i = 1'b1; en_i = 1'b1; rst_i = 1'b0;
    @(negedge clk);
    div_load_i = 1'b0;
    repeat (3 * n) @(negedge clk);
    wait_q(1'b0, tx, okx);
    wait_q(1'b1, t0, ok0);
    wait_q(1'b0, t1, ok1);
    wait_q(1'b1, t2, ok2);
    checks++;
    if (!(okx && ok0 && ok1 && ok2)) begin
      errors++;
      $display("FAIL duty_timeout n=%0d: q_o edges not seen within budget", n);
    end else begin
      check1($sformatf("high_time_n%0d", n), 0, int'(t1 - t0), exp_hi);
      check1($sformatf("low_time_n%0d", n), 0, int'(t2 - t1), exp_lo);
    end
  endtask

  initial begin
    // rst en ld div | q tick div_o err
    add(1,0,0,0, 0,0,3,0);
    add(1,0,0,0, 0,0,3,0);
    add(0,1,0,0, 1,1,3,0);   // first enabled edge: tick and q together
    add(0,1,0,0, 0,0,3,0);
    add(0,1,0,0, 0,0,3,0);
    add(0,1,0,0, 1,1,3,0);
    add(0,1,0,0, 0,0,3,0);   // cnt=1
    add(0,1,1,8, 0,0,3,0);   // load 8 mid-period -> pending
    add(0,1,0,0, 1,1,8,0);   // boundary applies 8
    add(0,1,0,0, 1,0,8,0);
    add(0,1,0,0, 1,0,8,0);
    add(0,1,0,0, 1,0,8,0);
    add(0,1,0,0, 0,0,8,0);
    add(0,1,0,0, 0,0,8,0);
    add(0,1,0,0, 0,0,8,0);
    add(0,1,0,0, 0,0,8,0);
    add(0,1,0,0, 1,1,8,0);
    add(0,1,1,0, 1,0,8,1);   // div_i=0 -> error pulse
    add(0,1,0,0, 1,0,8,0);
    add(0,1,1,1, 1,0,8,1);   // div_i=1 -> error pulse
    add(0,1,0,0, 0,0,8,0);
    add(0,1,0,0, 0,0,8,0);
    add(0,1,0,0, 0,0,8,0);
    add(0,1,0,0, 0,0,8,0);
    add(0,1,0,0, 1,1,2,0);   // clamped to 2
    add(0,1,0,0, 0,0,2,0);
    add(0,1,0,0, 1,1,2,0);
    add(0,1,0,0, 0,0,2,0);
    add(0,1,1,5, 1,1,5,0);   // load on wrap edge bypasses pending
    add(0,1,0,0, 1,0,5,0);
    add(0,1,0,0, 0,0,5,0);   // cnt=2
    add(0,0,0,0, 0,0,5,0);   // en dropped: no tick
    add(0,0,0,0, 0,0,5,0);
    add(0,1,0,0, 1,1,5,0);   // re-enable: fresh period
    add(0,1,0,0, 1,0,5,0);
    add(0,1,0,0, 0,0,5,0);
    add(0,1,0,0, 0,0,5,0);
    add(0,1,0,0, 0,0,5,0);
    add(0,1,0,0, 1,1,5,0);
    add(0,1,1,9, 1,0,5,0);   // pending 9
    add(1,1,0,0, 0,0,3,0);   // reset discards pending
    add(1,1,0,0, 0,0,3,0);
    add(0,1,0,0, 1,1,3,0);
    add(0,1,0,0, 0,0,3,0);
    add(0,1,0,0, 0,0,3,0);
    add(0,1,0,0, 1,1,3,0);   // still 3, not 9
    add(0,1,1,4, 0,0,3,0);   // pending 4
    add(0,0,0,0, 0,0,4,0);   // idle applies pending at once
    add(0,1,0,0, 1,1,4,0);
    add(0,1,0,0, 1,0,4,0);
    add(0,1,0,0, 0,0,4,0);
    add(0,1,0,0, 0,0,4,0);
    add(0,1,0,0, 1,1,4,0);
    add(0,1,1,6, 1,0,4,0);
    add(0,1,1,7, 0,0,4,0);   // last load wins
    add(0,1,0,0, 0,0,4,0);
    add(0,1,0,0, 1,1,7,0);
    add(0,1,0,0, 1,0,7,0);
    add(0,1,0,0, 1,0,7,0);
    add(0,1,0,0, 0,0,7,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_i = vecs[i].rst; en_i = vecs[i].en;
      div_load_i = vecs[i].load; div_i = vecs[i].div;
      @(posedge clk);
      #1;
      check1("q_o", i, int'(q_o), int'(vecs[i].q));
      check1("tick_o", i, int'(tick_o), int'(vecs[i].tick));
      check1("div_o", i, int'(div_o), int'(vecs[i].dv));
      check1("cfg_err_o", i, int'(cfg_err_o), int'(vecs[i].err));
    end

`ifdef CLK_DIV_ODD_DUTY50_EN
    measure(5, 25, 25);
`else
    measure(5, 20, 30);
`endif
    measure(4, 20, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
